enc_step_ctrl: RTL and testbench
================================

ENC_STEP_CTRL -- requirements
Module: enc_step_ctrl

Interface
REQ-001 SHALL have parameter MAX_POS, default 19, meaning highest legal position (0..MAX_POS, MAX_POS <= 31).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, meaning lockout cycles after every applied update (>= 1).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port BTN  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port step_add  input  1  one-cycle increment pulse from encoder decoder.
REQ-006 SHALL have port step_sub  input  1  one-cycle decrement pulse from encoder decoder.
REQ-007 SHALL have port ld_req  input  1  host load request, level, held until ld_ack.
REQ-008 SHALL have port ld_val  input  5  host load value, sampled when load accepted.
REQ-009 SHALL have port ld_ack  output  1  one-cycle pulse: load accepted and applied.
REQ-010 SHALL have port pos  output  5  current position, registered.
REQ-011 SHALL have port upd  output  1  one-cycle pulse in cycle after pos changes value or is loaded.
REQ-012 SHALL have port LED  output  2  last source: 00 none, 01 add, 10 sub, 11 load.

Function
REQ-013 SHALL implement FSM states IDLE, APPLY, HOLD; transitions IDLE->APPLY on work pending, APPLY->HOLD unconditionally, HOLD->IDLE after HOLD_CYCLES cycles in HOLD.
REQ-014 SHALL latch step_add into pend_add and step_sub into pend_sub in any state; pulses never lost during APPLY/HOLD.
REQ-015 SHALL retain a pulse arriving in the same cycle its pending flag is consumed (set wins over clear).
REQ-016 SHALL treat work pending in IDLE as: ld_req high, or pend_add, or pend_sub.
REQ-017 SHALL give ld_req priority over pending steps when both present in IDLE.
REQ-018 SHALL, in APPLY for a load: pos <= min(ld_val, MAX_POS), ld_ack = 1 for that cycle, LED <= 11, clear pend_add and pend_sub.
REQ-019 SHALL, in APPLY for steps with pend_add only: pos <= pos+1, wrap MAX_POS -> 0, LED <= 01, clear pend_add.
REQ-020 SHALL, in APPLY for steps with pend_sub only: pos <= pos-1, wrap 0 -> MAX_POS, LED <= 10, clear pend_sub.
REQ-021 SHALL, in APPLY with both pend_add and pend_sub: clear both, pos and LED unchanged, no upd.
REQ-022 SHALL assert upd exactly one cycle, in the cycle after APPLY, when pos changed or a load occurred (including a load of the current value).
REQ-023 SHALL sample ld_req only in IDLE; ld_req asserted during APPLY/HOLD waits, ld_val sampled at acceptance.
REQ-024 SHALL limit applied updates to at most one per HOLD_CYCLES+1 cycles; minimum IDLE-to-IDLE loop HOLD_CYCLES+2 cycles.
REQ-025 SHALL use HOLD counter width ceil(log2(HOLD_CYCLES+1)), no overflow.

Reset
REQ-026 SHALL, while BTN high, force state IDLE, pos = 0, LED = 00, ld_ack = 0, upd = 0, pend_add = pend_sub = 0, hold counter = 0, immediately and independent of clk.
REQ-027 SHALL abort any in-progress APPLY/HOLD on BTN without applying it; pulses during reset discarded.
REQ-028 SHALL resume normal operation on first rising clk edge after BTN deasserts.

Verification
REQ-029 SHALL pass: reset, single step_add pulse -> APPLY next cycle, pos 0->1, LED 01, upd one cycle, next step not applied for 4 cycles.
REQ-030 SHALL pass: pos = 19, step_add -> pos 0; pos = 0, step_sub -> pos 19, LED 10.
REQ-031 SHALL pass: step_add and step_sub in the same cycle from IDLE -> pos unchanged, no upd, FSM returns to IDLE after HOLD.
REQ-032 SHALL pass: ld_req with ld_val = 25 while pend_add set -> pos 19, ld_ack one cycle, LED 11, pend_add cleared, pos never 20.
REQ-033 SHALL pass: three step_add pulses during HOLD -> only one increment applied after HOLD (pend_add is 1-bit).
REQ-034 SHALL pass: BTN asserted mid-HOLD with pend_sub set -> pos 0, LED 00, no further update after release until new pulse.

Source files
------------

// File: rtl/enc_step_ctrl_if.sv
// Encoder step controller bus: step pulses, host load handshake and status.
interface enc_step_ctrl_if;
  logic       step_add;
  logic       step_sub;
  logic       ld_req;
  logic [4:0] ld_val;
  logic       ld_ack;
  logic [4:0] pos;
  logic       upd;
  logic [1:0] LED;

  modport master (
    output step_add, step_sub, ld_req, ld_val,
    input  ld_ack, pos, upd, LED
  );

  modport slave (
    input  step_add, step_sub, ld_req, ld_val,
    output ld_ack, pos, upd, LED
  );
endinterface

// File: rtl/enc_step_ctrl.sv
// Position controller driven by encoder step pulses and host loads.
// One update is applied per IDLE->APPLY->HOLD loop; the HOLD lockout
// rate-limits updates while pulses arriving meanwhile are kept pending.
module enc_step_ctrl #(
  parameter int MAX_POS     = 19,
  parameter int HOLD_CYCLES = 4
) (
  input logic            clk,
  input logic            BTN,
  enc_step_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [4:0]       POS_MAX  = 5'(MAX_POS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_sel_q, ld_sel_d;
  logic             pend_add_q, pend_sub_q;
  logic             clr_add, clr_sub;
  logic [4:0]       pos_q, pos_d;
  logic [1:0]       led_q, led_d;
  logic             upd_q, upd_d;
  logic             ack;

  // Host values above the legal range saturate at the top position.
  function automatic logic [4:0] clamp_pos(input logic [4:0] v);
    return (v > POS_MAX) ? POS_MAX : v;
  endfunction

  function automatic logic [4:0] inc_wrap(input logic [4:0] p);
    return (p == POS_MAX) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic [4:0] dec_wrap(input logic [4:0] p);
    return (p == 5'd0) ? POS_MAX : p - 5'd1;
  endfunction

  // Next-state, datapath update and handshake decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_sel_d = ld_sel_q;
    pos_d    = pos_q;
    led_d    = led_q;
    upd_d    = 1'b0;
    clr_add  = 1'b0;
    clr_sub  = 1'b0;
    ack      = 1'b0;
    case (state_q)
      IDLE: begin
        // A load outranks pending steps; the choice is frozen for APPLY.
        if (bus.ld_req || pend_add_q || pend_sub_q) begin
          state_d  = APPLY;
          ld_sel_d = bus.ld_req;
        end
      end
      APPLY: begin
        state_d = HOLD;
        cnt_d   = '0;
        if (ld_sel_q) begin
          pos_d   = clamp_pos(bus.ld_val);
          led_d   = 2'b11;
          upd_d   = 1'b1;
          ack     = 1'b1;
          clr_add = 1'b1;
          clr_sub = 1'b1;
        end else if (pend_add_q && !pend_sub_q) begin
          pos_d   = inc_wrap(pos_q);
          led_d   = 2'b01;
          upd_d   = 1'b1;
          clr_add = 1'b1;
        end else if (pend_sub_q && !pend_add_q) begin
          pos_d   = dec_wrap(pos_q);
          led_d   = 2'b10;
          upd_d   = 1'b1;
          clr_sub = 1'b1;
        end else begin
          // Opposing steps cancel without touching position or source.
          clr_add = 1'b1;
          clr_sub = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, pending flags and outputs; BTN clears everything at once.
  always_ff @(posedge clk or posedge BTN) begin
    if (BTN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_sel_q   <= 1'b0;
      pend_add_q <= 1'b0;
      pend_sub_q <= 1'b0;
      pos_q      <= 5'd0;
      led_q      <= 2'b00;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_sel_q   <= ld_sel_d;
      // A fresh pulse wins over a same-cycle clear so it is never lost.
      pend_add_q <= bus.step_add | (pend_add_q & ~clr_add);
      pend_sub_q <= bus.step_sub | (pend_sub_q & ~clr_sub);
      pos_q      <= pos_d;
      led_q      <= led_d;
      upd_q      <= upd_d;
    end
  end

  assign bus.pos    = pos_q;
  assign bus.LED    = led_q;
  assign bus.upd    = upd_q;
  assign bus.ld_ack = ack;

endmodule

// File: tb/tb_enc_step_ctrl.sv
// Bench for enc_step_ctrl: directed scenarios then random pulses/loads,
// checked every cycle against a cycle-count based reference model.
module tb_enc_step_ctrl;
  localparam int MAX  = 19;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic BTN = 1'b1;
  enc_step_ctrl_if bus();

  enc_step_ctrl #(.MAX_POS(MAX), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk),
    .BTN(BTN),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: absolute cycle numbers for the next apply and the
  // first cycle the controller is free again.
  int cyc = 0;
  int m_pos, m_led, m_upd;
  int m_apply_at, m_idle_at;
  bit m_apply_load, m_pa, m_ps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_led = 0; m_upd = 0;
    m_pa = 0; m_ps = 0;
    m_apply_at = -1; m_idle_at = cyc; m_apply_load = 0;
  endtask

  task automatic model_next();
    int nu;
    nu = 0;
    if (cyc == m_apply_at) begin
      if (m_apply_load) begin
        m_pos = (int'(bus.ld_val) > MAX) ? MAX : int'(bus.ld_val);
        m_led = 3; nu = 1; m_pa = 0; m_ps = 0;
      end else if (m_pa && !m_ps) begin
        m_pos = (m_pos == MAX) ? 0 : m_pos + 1;
        m_led = 1; nu = 1; m_pa = 0;
      end else if (m_ps && !m_pa) begin
        m_pos = (m_pos == 0) ? MAX : m_pos - 1;
        m_led = 2; nu = 1; m_ps = 0;
      end else begin
        m_pa = 0; m_ps = 0;
      end
    end else if (cyc >= m_idle_at && (bus.ld_req || m_pa || m_ps)) begin
      m_apply_at   = cyc + 1;
      m_idle_at    = cyc + 2 + HOLD;
      m_apply_load = bus.ld_req;
    end
    if (bus.step_add) m_pa = 1;
    if (bus.step_sub) m_ps = 1;
    m_upd = nu;
  endtask

  // One clock: compare outputs mid-cycle, advance model, release pulses.
  task automatic step();
    bit exp_ack;
    exp_ack = (cyc == m_apply_at) && m_apply_load;
    @(negedge clk);
    chk("pos", 32'(bus.pos), 32'(m_pos));
    chk("led", 32'(bus.LED), 32'(m_led));
    chk("upd", 32'(bus.upd), 32'(m_upd));
    chk("ld_ack", 32'(bus.ld_ack), 32'(exp_ack));
    model_next();
    @(posedge clk); #1;
    bus.step_add = 1'b0;
    bus.step_sub = 1'b0;
    if (exp_ack) bus.ld_req = 1'b0;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset with a step pulse held throughout to be discarded.
  task automatic do_reset();
    BTN = 1'b1;
    bus.step_sub = 1'b1;
    #2;
    chk("rst_pos", 32'(bus.pos), 32'd0);
    chk("rst_led", 32'(bus.LED), 32'd0);
    chk("rst_upd", 32'(bus.upd), 32'd0);
    chk("rst_ack", 32'(bus.ld_ack), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    BTN = 1'b0;
    bus.step_sub = 1'b0;
    bus.ld_req = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.step_add = 1'b0;
    bus.step_sub = 1'b0;
    bus.ld_req   = 1'b0;
    bus.ld_val   = 5'd0;
    @(posedge clk); #1;
    do_reset();

    // Single step, then a second one arriving just after it is applied.
    bus.step_add = 1'b1; step();
    run(2);
    bus.step_add = 1'b1; step();
    run(12);
    chk("s1_pos", 32'(bus.pos), 32'd2);
    chk("s1_led", 32'(bus.LED), 32'd1);

    // Load top position, then wrap both directions.
    bus.ld_req = 1'b1; bus.ld_val = 5'd19; step();
    run(10);
    chk("s2_load", 32'(bus.pos), 32'd19);
    bus.step_add = 1'b1; step();
    run(10);
    chk("s2_wrap_up", 32'(bus.pos), 32'd0);
    bus.step_sub = 1'b1; step();
    run(10);
    chk("s2_wrap_dn", 32'(bus.pos), 32'd19);
    chk("s2_led", 32'(bus.LED), 32'd2);

    // Opposing steps together cancel.
    bus.step_add = 1'b1; bus.step_sub = 1'b1; step();
    run(10);
    chk("s3_pos", 32'(bus.pos), 32'd19);
    chk("s3_led", 32'(bus.LED), 32'd2);

    // Over-range load beats a pending increment; increment discarded.
    bus.step_sub = 1'b1; step();
    run(10);
    bus.step_add = 1'b1; bus.ld_req = 1'b1; bus.ld_val = 5'd25; step();
    run(14);
    chk("s4_pos", 32'(bus.pos), 32'd19);
    chk("s4_led", 32'(bus.LED), 32'd3);

    // Three pulses during HOLD collapse into one increment.
    bus.step_add = 1'b1; step();
    run(2);
    for (int i = 0; i < 3; i++) begin
      bus.step_add = 1'b1; step();
    end
    run(15);
    chk("s5_pos", 32'(bus.pos), 32'd1);

    // Reset mid-HOLD with a decrement pending.
    bus.step_add = 1'b1; step();
    run(2);
    bus.step_sub = 1'b1; step();
    step();
    do_reset();
    run(12);
    chk("s6_pos", 32'(bus.pos), 32'd0);
    chk("s6_led", 32'(bus.LED), 32'd0);

    // Random pulses and loads.
    for (int i = 0; i < 400; i++) begin
      bus.step_add = ($urandom_range(0, 4) == 0);
      bus.step_sub = ($urandom_range(0, 4) == 0);
      if (!bus.ld_req && $urandom_range(0, 15) == 0) begin
        bus.ld_req = 1'b1;
        bus.ld_val = 5'($urandom_range(0, 31));
      end
      step();
    end
    bus.ld_req = 1'b0;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
